// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// per-stage stall vectors ({wb,mem,ex,id,if,pc}) and reset polarity.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CtrlRun    = 2'd0,
        CtrlExWait = 2'd1,
        CtrlFlush  = 2'd2
    } ctrl_state_e;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallID   = 6'b000111;
    localparam logic [5:0] StallEX   = 6'b001111;
    localparam logic [5:0] StallMEM  = 6'b011111;

    localparam logic RstEnable = 1'b0;

    localparam int unsigned MemWaitW = 10;

endpackage

// File: rtl/pipe_ctrl_mc_down_counter.sv
// Loadable down-counter for the EX multi-cycle countdown: clear beats load,
// load beats decrement, and it never wraps below zero.
module pipe_ctrl_mc_down_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates ID/EX/MEM stall requests,
// runs the EX multi-cycle countdown and MEM timeout, and issues flush/new_pc.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    output logic             ex_mc_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             bus_err,
    input  logic             excp_valid,
    input  logic [31:0]      excp_handler,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc
);

    localparam logic [MemWaitW-1:0] TimeoutVal = MemWaitW'(MEM_TIMEOUT);

    ctrl_state_e         state_q;
    logic                flush_q;
    logic [31:0]         new_pc_q;
    logic [MemWaitW-1:0] mem_wait_q;
    logic [MemWaitW-1:0] mem_wait_d;

    logic             excp_take;
    logic             mem_pending;
    logic             mem_timeout;
    logic             mem_stall;
    logic             ex_stall;
    logic             mc_start;
    logic             mc_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] len_m1;

    // An exception arriving while FLUSH is already in progress is ignored.
    assign excp_take   = excp_valid && (state_q != CtrlFlush);
    assign mem_pending = mem_req && !mem_ack;
    assign mem_timeout = mem_pending && (mem_wait_q == TimeoutVal);
    assign mem_stall   = mem_pending && !mem_timeout;

    assign mc_start = (state_q == CtrlRun) && ex_mc_start && !excp_valid;
    assign mc_dec   = (state_q == CtrlExWait) && !mem_stall && !excp_take;
    assign ex_stall = ((state_q == CtrlRun) && ex_mc_start) ||
                      ((state_q == CtrlExWait) && !cnt_zero);
    assign len_m1   = (ex_mc_len == '0) ? '0 : ex_mc_len - 1'b1;

    pipe_ctrl_mc_down_counter #(
        .W(CNT_W)
    ) u_ex_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (excp_take),
        .load_i     (mc_start),
        .load_val_i (len_m1),
        .dec_i      (mc_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        stall = StallNone;
        if ((rst == RstEnable) || excp_valid || (state_q == CtrlFlush)) begin
            stall = StallNone;
        end else if (mem_stall) begin
            stall = StallMEM;
        end else if (ex_stall) begin
            stall = StallEX;
        end else if (stallreq_id) begin
            stall = StallID;
        end
    end

    assign ex_mc_done = (rst != RstEnable) && (state_q == CtrlExWait) &&
                        cnt_zero && !excp_take;
    assign bus_err    = (rst != RstEnable) && mem_timeout;

    always_comb begin
        mem_wait_d = mem_wait_q + 1'b1;
        if (excp_take || !mem_pending || mem_timeout) begin
            mem_wait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            mem_wait_q <= '0;
        end else begin
            mem_wait_q <= mem_wait_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q  <= CtrlRun;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            flush_q <= 1'b0;
            if (excp_take) begin
                state_q  <= CtrlFlush;
                flush_q  <= 1'b1;
                new_pc_q <= excp_handler;
            end else begin
                case (state_q)
                    CtrlRun: begin
                        if (ex_mc_start) begin
                            state_q <= CtrlExWait;
                        end
                    end
                    CtrlExWait: begin
                        if (cnt_zero) begin
                            state_q <= CtrlRun;
                        end
                    end
                    default: state_q <= CtrlRun;
                endcase
            end
        end
    end

    assign flush  = flush_q;
    assign new_pc = new_pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_len;
    logic             ex_mc_done;
    logic             mem_req;
    logic             mem_ack;
    logic             bus_err;
    logic             excp_valid;
    logic [31:0]      excp_handler;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .ex_mc_done   (ex_mc_done),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .bus_err      (bus_err),
        .excp_valid   (excp_valid),
        .excp_handler (excp_handler),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: "cycles of EX work left" view of the multi-cycle op.
    bit          m_flush;
    logic [31:0] m_pc;
    bit          m_in_flush;
    bit          m_mc_busy;
    int          m_mc_left;
    int          m_wait;

    logic [5:0]  s_stall;
    logic        s_done;
    logic        s_err;
    logic        s_flush;
    logic [31:0] s_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush    = 1'b0;
        m_pc       = '0;
        m_in_flush = 1'b0;
        m_mc_busy  = 1'b0;
        m_mc_left  = 0;
        m_wait     = 0;
    endtask

    task automatic clear_inputs();
        stallreq_id  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = '0;
        mem_req      = 1'b0;
        mem_ack      = 1'b0;
        excp_valid   = 1'b0;
        excp_handler = '0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit pending, tmo, memst, exc, exst;
        logic [5:0] es;
        int len;
        @(negedge clk);
        pending = mem_req && !mem_ack;
        tmo     = pending && (m_wait == TO);
        memst   = pending && !tmo;
        exc     = excp_valid && !m_in_flush;
        exst    = (!m_in_flush && !m_mc_busy && ex_mc_start) || (m_mc_busy && m_mc_left > 0);
        if (excp_valid || m_in_flush) es = 6'b000000;
        else if (memst)               es = 6'b011111;
        else if (exst)                es = 6'b001111;
        else if (stallreq_id)         es = 6'b000111;
        else                          es = 6'b000000;
        s_stall = stall; s_done = ex_mc_done; s_err = bus_err; s_flush = flush; s_pc = new_pc;
        check("stall",   32'(stall),      32'(es));
        check("mc_done", 32'(ex_mc_done), 32'(m_mc_busy && m_mc_left == 0 && !exc));
        check("bus_err", 32'(bus_err),    32'(tmo));
        check("flush",   32'(flush),      32'(m_flush));
        check("new_pc",  new_pc,          m_pc);
        @(posedge clk);
        m_flush = exc;
        if (exc) m_pc = excp_handler;
        m_wait = (exc || !pending || tmo) ? 0 : m_wait + 1;
        if (exc) begin
            m_mc_busy = 1'b0;
        end else if (m_mc_busy) begin
            if (m_mc_left == 0) m_mc_busy = 1'b0;
            else if (!memst)    m_mc_left--;
        end else if (!m_in_flush && ex_mc_start) begin
            len = (ex_mc_len == 0) ? 1 : int'(ex_mc_len);
            m_mc_busy = 1'b1;
            m_mc_left = len - 1;
        end
        m_in_flush = exc;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},  32'(stall),      32'd0);
        check({tag, "_flush"},  32'(flush),      32'd0);
        check({tag, "_newpc"},  new_pc,          32'd0);
        check({tag, "_done"},   32'(ex_mc_done), 32'd0);
        check({tag, "_buserr"}, 32'(bus_err),    32'd0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_len = 6'd3;
        mem_req = 1'b1; excp_valid = 1'b1; excp_handler = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst_hold");
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        check("rst_idle", 32'(s_stall), 32'd0);

        // load-use for one cycle
        stallreq_id = 1'b1; step();
        check("lu_stall", 32'(s_stall), 32'b000111);
        stallreq_id = 1'b0; step();
        check("lu_release", 32'(s_stall), 32'd0);

        // L=4: stall T..T+3, done at T+4 only
        ex_mc_start = 1'b1; ex_mc_len = 6'd4; step();
        check("l4_stall_T", 32'(s_stall), 32'b001111);
        ex_mc_start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            check("l4_stall", 32'(s_stall), 32'b001111);
            check("l4_nodone", 32'(s_done), 32'd0);
        end
        step();
        check("l4_done", 32'(s_done), 32'd1);
        check("l4_free", 32'(s_stall), 32'd0);
        step();
        check("l4_done_once", 32'(s_done), 32'd0);

        // L=0 behaves as L=1
        ex_mc_start = 1'b1; ex_mc_len = 6'd0; step();
        check("l0_stall", 32'(s_stall), 32'b001111);
        ex_mc_start = 1'b0; step();
        check("l0_done", 32'(s_done), 32'd1);

        // MEM stall during EX_WAIT delays done by three cycles
        ex_mc_start = 1'b1; ex_mc_len = 6'd4; step();
        ex_mc_start = 1'b0; step();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mex_stall", 32'(s_stall), 32'b011111);
        end
        mem_ack = 1'b1; step();
        check("mex_ack", 32'(s_stall), 32'b001111);
        mem_req = 1'b0; mem_ack = 1'b0; step();
        check("mex_nodone", 32'(s_done), 32'd0);
        step();
        check("mex_done", 32'(s_done), 32'd1);

        // MEM timeout
        mem_req = 1'b1;
        for (int i = 0; i < TO; i++) begin
            step();
            check("to_stall", 32'(s_stall), 32'b011111);
            check("to_noerr", 32'(s_err), 32'd0);
        end
        step();
        check("to_err", 32'(s_err), 32'd1);
        check("to_release", 32'(s_stall), 32'd0);
        mem_req = 1'b0; step();

        // exception aborts EX_WAIT
        ex_mc_start = 1'b1; ex_mc_len = 6'd5; step();
        ex_mc_start = 1'b0; step();
        excp_valid = 1'b1; excp_handler = 32'hBFC0_0380; step();
        check("exc_stall", 32'(s_stall), 32'd0);
        excp_valid = 1'b0; step();
        check("exc_flush", 32'(s_flush), 32'd1);
        check("exc_pc", s_pc, 32'hBFC0_0380);
        for (int i = 0; i < 6; i++) begin
            step();
            check("exc_nodone", 32'(s_done), 32'd0);
            check("exc_flush_once", 32'(s_flush), 32'd0);
        end

        // randomized traffic with occasional mid-operation reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stallreq_id  = ($urandom_range(0, 3) == 0);
            ex_mc_start  = ($urandom_range(0, 5) == 0);
            ex_mc_len    = CNT_W'($urandom_range(0, 9));
            if (!mem_req) mem_req = ($urandom_range(0, 3) == 0);
            else          mem_req = ($urandom_range(0, 15) != 0);
            mem_ack      = mem_req && ($urandom_range(0, 9) == 0);
            excp_valid   = ($urandom_range(0, 24) == 0);
            excp_handler = $urandom;
            if ((cyc % 700) == 350) begin
                rst = 1'b0;
                #2;
                check_reset_outputs("rst_mid");
                @(posedge clk); #2;
                rst = 1'b1;
                model_reset();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core.
- Collects stall requests from ID (load-use), EX (multi-cycle ops) and MEM (bus wait), and exception requests from MEM.
- Drives the per-stage stall vector and flush/new-PC to pc_reg and to the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Owns the multi-cycle EX countdown and the MEM bus-wait timeout.

Parameters:
- CNT_W, 6, width of the EX multi-cycle length/counter.
- MEM_TIMEOUT, 255, maximum MEM wait cycles before bus error (must be < 2^10).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- stallreq_id  in  1  ID load-use hazard, level, same-cycle.
- ex_mc_start  in  1  EX begins a multi-cycle op this cycle (pulse).
- ex_mc_len  in  CNT_W  total op length L in cycles; 0 treated as 1.
- ex_mc_done  out  1  one-cycle pulse: multi-cycle result may be captured.
- mem_req  in  1  MEM stage bus access pending.
- mem_ack  in  1  bus access complete this cycle.
- bus_err  out  1  one-cycle pulse on MEM timeout.
- excp_valid  in  1  exception committed in MEM this cycle.
- excp_handler  in  32  handler address.
- stall  out  6  {wb,mem,ex,id,if,pc}; bit set holds that stage.
- flush  out  1  clear all pipeline registers to NOP.
- new_pc  out  32  PC to load when flush=1.

Behaviour:
- Reset (rst=0, async): state=RUN, counters=0, flush=0, new_pc=0, ex_mc_done=0, bus_err=0. stall is forced to 000000 combinationally while rst=0.
- States: RUN, EX_WAIT, FLUSH. The 10-bit mem_wait_cnt is independent of state.
- Stall priority (combinational, same cycle), highest first:
  - excp_valid or state FLUSH -> 000000.
  - mem_req & !mem_ack & no timeout -> 011111.
  - EX stall (ex_mc_start in RUN, or EX_WAIT with cnt!=0) -> 001111.
  - stallreq_id -> 000111.
  - otherwise 000000.
- EX multi-cycle:
  - ex_mc_start in RUN at cycle T: cnt <= max(L,1)-1, state -> EX_WAIT.
  - EX_WAIT with cnt!=0: cnt decrements each cycle, unless a MEM stall is active (then cnt holds).
  - EX_WAIT with cnt==0: ex_mc_done=1 (combinational), no EX stall, state -> RUN.
  - Net effect with no MEM stall: stall asserted T..T+L-1, done at T+L.
  - ex_mc_start outside RUN is ignored.
- MEM wait:
  - mem_wait_cnt increments on each cycle with mem_req & !mem_ack; clears on ack, on !mem_req, or on exception.
  - When mem_wait_cnt reaches MEM_TIMEOUT: bus_err pulses that cycle, MEM stall is released that cycle, and the counter clears.
  - mem_ack in the same cycle as the timeout: ack wins, no bus_err.
- Exception:
  - excp_valid at T: flush<=1, new_pc<=excp_handler at the T edge, state -> FLUSH.
  - Any EX_WAIT is aborted (cnt cleared, no ex_mc_done).
  - FLUSH lasts exactly one cycle, then RUN.
  - excp_valid during FLUSH is ignored.
  - flush=0 in all other states; new_pc holds its last value.
- Simultaneous ex_mc_start and excp_valid: exception wins, the start is dropped.
- Reset asserted mid-operation: immediate return to reset values; no done/err pulse is emitted.

Decomposition:
- defines.v gets the stall encodings (StallNone, StallID, StallEX, StallMEM), state codes (CtrlRun, CtrlExWait, CtrlFlush), and RstEnable redefined as 1'b0 for this block's polarity.
- One natural sub-module: mc_down_counter (loadable, hold-enable, zero flag). It is instantiated for the EX countdown.

Test Plan:
- Reset: hold rst=0 with all requests high -> stall=000000, flush=0, new_pc=0; after release with no requests, stall=000000.
- Load-use: stallreq_id=1 for 1 cycle -> stall=000111 that cycle only.
- EX multi-cycle: ex_mc_start with L=4 at T -> stall=001111 T..T+3, ex_mc_done=1 at T+4 only; L=0 -> stall at T, done at T+1.
- MEM over EX: during EX_WAIT (cnt=2), hold mem_req=1 for 3 cycles then mem_ack -> stall=011111 for 3 cycles, cnt held, and done arrives 3 cycles later than without the MEM stall.
- Timeout: mem_req=1, mem_ack=0 with MEM_TIMEOUT=8 -> stall=011111 for 8 cycles, bus_err pulse on the 9th cycle with stall released.
- Exception: excp_valid=1 with handler 0xBFC00380 during EX_WAIT -> stall=000000 that cycle; next cycle flush=1 and new_pc=0xBFC00380 for one cycle; ex_mc_done never pulses.
